// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store initiator for a word-wide async-read data memory
// Optional: define LSU_MISALIGN_ERR_EN to report misaligned half/word accesses as errors.
module load_store_unit #(
  parameter int ADDR_LIMIT = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, RMW_RD, RESP} state_t;

  state_t      state, state_nx;
  logic [1:0]  r_lane;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [15:0] r_wdata;
  logic        accept;
  logic        req_err;
  logic [31:0] eff_addr;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;
  logic [31:0] merged;

  assign accept     = req_valid && req_ready;
  assign req_ready  = (state == IDLE);
  assign mem_we     = (state == WRITE);
  assign resp_valid = (state == RESP);

  // Request decode: range and reserved-size errors, plus alignment handling.
  always_comb begin
    eff_addr = req_addr;
    if (req_size == 2'd1) eff_addr[0] = 1'b0;
    else if (req_size == 2'd2) eff_addr[1:0] = 2'b00;
    req_err = (req_size == 2'd3) || (req_addr >= 32'(ADDR_LIMIT));
`ifdef LSU_MISALIGN_ERR_EN
    req_err = req_err || (req_size == 2'd1 && req_addr[0])
                      || (req_size == 2'd2 && req_addr[1:0] != 2'b00);
`else
    req_err = req_err || 1'b0;
`endif
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    case (r_lane)
      2'd0:    ld_byte = mem_rd[7:0];
      2'd1:    ld_byte = mem_rd[15:8];
      2'd2:    ld_byte = mem_rd[23:16];
      default: ld_byte = mem_rd[31:24];
    endcase
    ld_half = r_lane[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (r_size)
      2'd0:    ld_val = {{24{~r_uns & ld_byte[7]}}, ld_byte};
      2'd1:    ld_val = {{16{~r_uns & ld_half[15]}}, ld_half};
      default: ld_val = mem_rd;
    endcase
    merged = mem_rd;
    if (r_size == 2'd0) begin
      case (r_lane)
        2'd0:    merged[7:0]   = r_wdata[7:0];
        2'd1:    merged[15:8]  = r_wdata[7:0];
        2'd2:    merged[23:16] = r_wdata[7:0];
        default: merged[31:24] = r_wdata[7:0];
      endcase
    end else if (r_lane[1]) begin
      merged[31:16] = r_wdata;
    end else begin
      merged[15:0] = r_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)               state_nx = RESP;
          else if (!req_we)          state_nx = LOAD;
          else if (req_size == 2'd2) state_nx = WRITE;
          else                       state_nx = RMW_RD;
        end
      end
      LOAD:    state_nx = RESP;
      RMW_RD:  state_nx = WRITE;
      WRITE:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // mem_a/mem_wd only move on the way into a memory state, so they hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lane     <= 2'd0;
      r_size     <= 2'd0;
      r_uns      <= 1'b0;
      r_wdata    <= 16'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      mem_a      <= 32'd0;
      mem_wd     <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            r_lane     <= eff_addr[1:0];
            r_size     <= req_size;
            r_uns      <= req_unsigned;
            r_wdata    <= req_wdata[15:0];
            resp_rdata <= 32'd0;
            resp_err   <= req_err;
            if (!req_err) mem_a <= {eff_addr[31:2], 2'b00};
            if (!req_err && req_we && req_size == 2'd2) mem_wd <= req_wdata;
          end
        end
        LOAD:    resp_rdata <= ld_val;
        RMW_RD:  mem_wd <= merged;
        default: ;
      endcase
    end
  end

endmodule
